// File: rtl/student_fir_scheduler.sv
// -----------------------------------------------------------------------------
// student_fir_scheduler
//
// Sequences a bank of NUM_UNITS FIR units that all filter the same sample.
// A rising edge on valid_strobe_in captures a sample and issues one start
// strobe to every unit. The scheduler then waits for each unit's done pulse,
// with a cycle-bounded timeout. Next it adds the unit results one per cycle
// into a wide signed accumulator. Finally it emits the sum, scaled by an
// arithmetic right shift and saturated to the sample width.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_strobe_in      new-sample strobe (rising edge is significant)
//   sample_in            input sample
//   clear_i              clears the sticky overrun/timeout flags
//   fir_valid_strobe_o   one-cycle start strobe to all units
//   fir_sample_o         sample handed to the units
//   fir_finished_i       per-unit one-cycle done pulses
//   fir_y_i              packed unit results, unit k at [k*W +: W]
//   sample_out           scaled, saturated sum (held until next result)
//   valid_strobe_out     one-cycle result strobe
//   busy_o               high while a computation is in flight
//   overrun_o            sticky: a sample edge arrived while busy
//   timeout_o            sticky: units failed to finish in time
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module student_fir_scheduler #(
  parameter int NUM_UNITS         = 4,
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int OUT_SHIFT         = 15,
  parameter int TIMEOUT           = 2048
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   valid_strobe_in,
  input  logic [DATA_SIZE-1:0]                   sample_in,
  input  logic                                   clear_i,
  output logic                                   fir_valid_strobe_o,
  output logic [DATA_SIZE-1:0]                   fir_sample_o,
  input  logic [NUM_UNITS-1:0]                   fir_finished_i,
  input  logic [NUM_UNITS*DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic [DATA_SIZE-1:0]                   sample_out,
  output logic                                   valid_strobe_out,
  output logic                                   busy_o,
  output logic                                   overrun_o,
  output logic                                   timeout_o
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  // Growth of log2(units) plus one guard bit makes overflow impossible.
  localparam int ACC_W = DATA_SIZE_FIR_OUT + $clog2(NUM_UNITS) + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_UNITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [DATA_SIZE-1:0] OUT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] OUT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'($signed(OUT_MAX));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'($signed(OUT_MIN));

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SUM,
    S_OUTPUT
  } state_t;

  state_t                    state_q;
  logic                      valid_prev_q;
  logic [NUM_UNITS-1:0]      done_q;
  logic [CNT_W-1:0]          wait_cnt_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic                      sample_edge;
  logic [NUM_UNITS-1:0]      done_next;
  logic                      all_done;
  logic                      wait_expired;
  logic signed [DATA_SIZE_FIR_OUT-1:0] unit_y;
  logic signed [ACC_W-1:0]   unit_ext;
  logic signed [ACC_W-1:0]   acc_shift;
  logic [DATA_SIZE-1:0]      sat_val;

  assign sample_edge  = valid_strobe_in & ~valid_prev_q;
  // Include this cycle's pulses so a unit finishing now is not missed.
  assign done_next    = done_q | fir_finished_i;
  assign all_done     = &done_next;
  assign wait_expired = (state_q == S_WAIT) && !all_done && (wait_cnt_q == CNT_LAST);

  assign unit_y    = fir_y_i[int'(idx_q)*DATA_SIZE_FIR_OUT +: DATA_SIZE_FIR_OUT];
  assign unit_ext  = ACC_W'(unit_y);
  assign acc_shift = acc_q >>> OUT_SHIFT;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sat_val = acc_shift[DATA_SIZE-1:0];
    if (acc_shift > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (acc_shift < SAT_MIN) begin
      sat_val = OUT_MIN;
    end
  end

  // NOTE: all state here, including the accumulator and mask, is small
  // register state, so every bit is cleared by the asynchronous reset;
  // sequential assignments are non-blocking so each register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= S_IDLE;
      valid_prev_q       <= 1'b0;
      done_q             <= '0;
      wait_cnt_q         <= '0;
      idx_q              <= '0;
      acc_q              <= '0;
      fir_valid_strobe_o <= 1'b0;
      fir_sample_o       <= '0;
      sample_out         <= '0;
      valid_strobe_out   <= 1'b0;
      busy_o             <= 1'b0;
      overrun_o          <= 1'b0;
      timeout_o          <= 1'b0;
    end else begin
      valid_prev_q       <= valid_strobe_in;
      fir_valid_strobe_o <= 1'b0;
      valid_strobe_out   <= 1'b0;

      // Sticky flags: a set in the same cycle as a clear wins.
      if (sample_edge && (state_q != S_IDLE)) begin
        overrun_o <= 1'b1;
      end else if (clear_i) begin
        overrun_o <= 1'b0;
      end

      if (wait_expired) begin
        timeout_o <= 1'b1;
      end else if (clear_i) begin
        timeout_o <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (sample_edge) begin
            fir_sample_o       <= sample_in;
            done_q             <= '0;
            acc_q              <= '0;
            wait_cnt_q         <= '0;
            idx_q              <= '0;
            fir_valid_strobe_o <= 1'b1;
            busy_o             <= 1'b1;
            state_q            <= S_START;
          end
        end

        S_START: begin
          done_q  <= done_next;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          done_q <= done_next;
          if (all_done || (wait_cnt_q == CNT_LAST)) begin
            idx_q   <= '0;
            state_q <= S_SUM;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_SUM: begin
          acc_q <= acc_q + unit_ext;
          if (idx_q == IDX_LAST) begin
            state_q <= S_OUTPUT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        S_OUTPUT: begin
          sample_out       <= sat_val;
          valid_strobe_out <= 1'b1;
          busy_o           <= 1'b0;
          state_q          <= S_IDLE;
        end

        default: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_scheduler.sv
// -----------------------------------------------------------------------------
// tb_student_fir_scheduler
//
// Directed bench for student_fir_scheduler with the default parameters.
// Inputs change 1 ns after a rising edge; outputs are read at that point,
// so they reflect the registered value for the current cycle. Cycle 0 is
// the cycle in which valid_strobe_in first goes high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_student_fir_scheduler;

  localparam int NU = 4;
  localparam int DS = 16;
  localparam int W  = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              valid_strobe_in;
  logic [DS-1:0]     sample_in;
  logic              clear_i;
  logic              fir_valid_strobe_o;
  logic [DS-1:0]     fir_sample_o;
  logic [NU-1:0]     fir_finished_i;
  logic [NU*W-1:0]   fir_y_i;
  logic [DS-1:0]     sample_out;
  logic              valid_strobe_out;
  logic              busy_o;
  logic              overrun_o;
  logic              timeout_o;

  int vectors     = 0;
  int miscompares = 0;
  int vs_count    = 0;

  student_fir_scheduler #(
    .NUM_UNITS(NU), .DATA_SIZE(DS), .DATA_SIZE_FIR_OUT(W),
    .OUT_SHIFT(15), .TIMEOUT(2048)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .valid_strobe_in    (valid_strobe_in),
    .sample_in          (sample_in),
    .clear_i            (clear_i),
    .fir_valid_strobe_o (fir_valid_strobe_o),
    .fir_sample_o       (fir_sample_o),
    .fir_finished_i     (fir_finished_i),
    .fir_y_i            (fir_y_i),
    .sample_out         (sample_out),
    .valid_strobe_out   (valid_strobe_out),
    .busy_o             (busy_o),
    .overrun_o          (overrun_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Independent count of result strobes, used for "exactly one result" checks.
  always @(negedge clk_i) begin
    if (valid_strobe_out) vs_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [NU*W-1:0] pack4(input logic [W-1:0] y0, input logic [W-1:0] y1,
                                            input logic [W-1:0] y2, input logic [W-1:0] y3);
    return {y3, y2, y1, y0};
  endfunction

  // One complete computation. f0..f3 are the cycles in which each unit pulses
  // done (0 = never). exp_cyc is the cycle valid_strobe_out is expected.
  task automatic run_op(input string tag, input logic [DS-1:0] smp, input logic [NU*W-1:0] y,
                        input int f0, input int f1, input int f2, input int f3,
                        input int exp_cyc, input logic [DS-1:0] exp_out, input logic exp_to);
    int got_cyc;
    int n;
    got_cyc = -1;
    n = 0;
    fir_y_i = y;
    sample_in = smp;
    valid_strobe_in = 1'b1;
    for (int c = 1; c <= 2200; c++) begin
      tick();
      valid_strobe_in = 1'b0;
      fir_finished_i = {f3 == c, f2 == c, f1 == c, f0 == c};
      if (c == 1) begin
        check({tag, "_start_strobe"}, 64'(fir_valid_strobe_o), 64'd1);
        check({tag, "_fir_sample"}, 64'(fir_sample_o), 64'(smp));
      end
      if (c == 2) check({tag, "_start_len"}, 64'(fir_valid_strobe_o), 64'd0);
      if (valid_strobe_out) begin
        n++;
        if (got_cyc < 0) begin
          got_cyc = c;
          check({tag, "_out"}, 64'(sample_out), 64'(exp_out));
        end
      end
      if (got_cyc >= 0 && c == got_cyc + 1) begin
        check({tag, "_strobe_len"}, 64'(valid_strobe_out), 64'd0);
        check({tag, "_hold"}, 64'(sample_out), 64'(exp_out));
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
        break;
      end
    end
    fir_finished_i = '0;
    check({tag, "_latency"}, 64'(got_cyc), 64'(exp_cyc));
    check({tag, "_count"}, 64'(n), 64'd1);
    check({tag, "_timeout"}, 64'(timeout_o), 64'(exp_to));
    repeat (2) tick();
  endtask

  localparam logic [W-1:0] Y8000 = 32'h0000_8000;

  int base;

  initial begin
    rst_ni = 1'b0;
    valid_strobe_in = 1'b0;
    sample_in = '0;
    clear_i = 1'b0;
    fir_finished_i = '0;
    fir_y_i = '0;
    #2;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_fir_strobe", 64'(fir_valid_strobe_o), 64'd0);
    check("rst_fir_sample", 64'(fir_sample_o), 64'd0);
    check("rst_sample_out", 64'(sample_out), 64'd0);
    check("rst_valid_out", 64'(valid_strobe_out), 64'd0);
    check("rst_flags", 64'({overrun_o, timeout_o}), 64'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (2) tick();

    // Basic: 4 x 0x8000 = 0x20000, >>>15 = 4; done at cycle 5 -> result cycle 11.
    run_op("basic", 16'h1234, pack4(Y8000, Y8000, Y8000, Y8000), 5, 5, 5, 5, 11, 16'h0004, 1'b0);
    check("basic_overrun", 64'(overrun_o), 64'd0);

    // Positive saturation: 4 x 0x7FFFFFFF >>> 15 = 0x3FFFF -> 0x7FFF.
    run_op("satpos", 16'h0001, pack4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
           3, 3, 3, 3, 9, 16'h7FFF, 1'b0);
    // Negative saturation: 4 x -2^31 >>> 15 = -0x40000 -> 0x8000.
    run_op("satneg", 16'h0002, pack4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
           2, 2, 2, 2, 8, 16'h8000, 1'b0);
    // All done during START; first WAIT cycle (2) completes -> cycle 8. -4 >>> 15 = -1.
    run_op("neg1", 16'h0003, pack4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
           1, 1, 1, 1, 8, 16'hFFFF, 1'b0);
    // Staggered finishes 1,3,7,2 -> last at 7 -> cycle 13. Sum 0x30000 >>> 15 = 6.
    run_op("stagger", 16'h0004, pack4(32'h0001_0000, 32'h0000_8000, 32'hFFFF_8000, 32'h0002_0000),
           1, 3, 7, 2, 13, 16'h0006, 1'b0);
    // Unit 2 never finishes: WAIT cycles 2..2049, SUM 2050..2053, OUTPUT 2054, strobe 2055.
    run_op("timeout", 16'h0005, pack4(Y8000, Y8000, Y8000, Y8000), 2, 2, 0, 2, 2055, 16'h0004, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("timeout_clear", 64'(timeout_o), 64'd0);

    // Overrun: second edge at cycle 3 with a simultaneous clear; set wins.
    base = vs_count;
    fir_y_i = pack4(Y8000, Y8000, Y8000, Y8000);
    sample_in = 16'h1111;
    valid_strobe_in = 1'b1;
    tick();                               // cycle 1
    valid_strobe_in = 1'b0;
    repeat (2) tick();                    // cycle 3
    valid_strobe_in = 1'b1;
    sample_in = 16'h2222;
    clear_i = 1'b1;
    tick();                               // cycle 4
    valid_strobe_in = 1'b0;
    clear_i = 1'b0;
    check("ovr_set", 64'(overrun_o), 64'd1);
    check("ovr_sample_kept", 64'(fir_sample_o), 64'h1111);
    tick();                               // cycle 5
    fir_finished_i = 4'hF;
    tick();
    fir_finished_i = '0;
    repeat (10) tick();
    check("ovr_one_result", 64'(vs_count - base), 64'd1);
    check("ovr_result", 64'(sample_out), 64'h0004);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("ovr_clear", 64'(overrun_o), 64'd0);

    // Edge during the OUTPUT cycle (cycle 10) is an overrun, not queued.
    base = vs_count;
    sample_in = 16'h0AAA;
    valid_strobe_in = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      valid_strobe_in = (c == 10);
      fir_finished_i = (c == 5) ? 4'hF : 4'h0;
      if (c == 11) begin
        check("outedge_result", 64'(valid_strobe_out), 64'd1);
        check("outedge_overrun", 64'(overrun_o), 64'd1);
      end
      if (c == 12) check("outedge_not_started", 64'(busy_o), 64'd0);
    end
    check("outedge_one_result", 64'(vs_count - base), 64'd1);
    check("outedge_sample_kept", 64'(fir_sample_o), 64'h0AAA);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;

    // Level held high for 100 cycles: one computation only.
    base = vs_count;
    sample_in = 16'h0BBB;
    valid_strobe_in = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      valid_strobe_in = (c < 100);
      fir_finished_i = (c == 5) ? 4'hF : 4'h0;
    end
    check("held_one_result", 64'(vs_count - base), 64'd1);
    check("held_no_overrun", 64'(overrun_o), 64'd0);

    // Reset during WAIT abandons the computation.
    base = vs_count;
    sample_in = 16'h0CCC;
    valid_strobe_in = 1'b1;
    tick();                               // cycle 1
    valid_strobe_in = 1'b0;
    repeat (2) tick();                    // cycle 3, WAIT
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_fir_sample", 64'(fir_sample_o), 64'd0);
    check("midrst_sample_out", 64'(sample_out), 64'd0);
    check("midrst_strobes", 64'({fir_valid_strobe_o, valid_strobe_out}), 64'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    fir_finished_i = 4'hF;
    tick();
    fir_finished_i = '0;
    repeat (15) tick();
    check("midrst_no_result", 64'(vs_count - base), 64'd0);
    run_op("post_rst", 16'h0DDD, pack4(Y8000, Y8000, Y8000, Y8000), 5, 5, 5, 5, 11, 16'h0004, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/student_fir_scheduler.md
STUDENT_FIR_SCHEDULER -- requirements
Module: student_fir_scheduler

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of FIR units sequenced (1..16).
REQ-002 SHALL have parameter DATA_SIZE, default 16, input sample width.
REQ-003 SHALL have parameter DATA_SIZE_FIR_OUT, default 32, width of each unit's y result.
REQ-004 SHALL have parameter OUT_SHIFT, default 15, arithmetic right shift applied before output saturation.
REQ-005 SHALL have parameter TIMEOUT, default 2048, maximum WAIT cycles.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  reset.
REQ-007 SHALL have these ports:
- valid_strobe_in  in  1  new-sample strobe; rising edge is significant.
- sample_in  in  DATA_SIZE  input sample.
- clear_i  in  1  clears sticky flags.
- fir_valid_strobe_o  out  1  start strobe to all units.
- fir_sample_o  out  DATA_SIZE  sample to unit 0.
- fir_finished_i  in  NUM_UNITS  per-unit one-cycle done pulses.
- fir_y_i  in  NUM_UNITS*DATA_SIZE_FIR_OUT  packed unit results, unit k at bits [k*W +: W].
- sample_out  out  DATA_SIZE  scaled, saturated sum.
- valid_strobe_out  out  1  one-cycle result strobe.
- busy_o  out  1  high whenever state != IDLE.
- overrun_o  out  1  sticky: sample dropped.
- timeout_o  out  1  sticky: units failed to finish.

Function
REQ-008 SHALL detect rising edges of valid_strobe_in with a registered previous value; a level held high SHALL produce one edge only.
REQ-009 SHALL implement states IDLE, START, WAIT, SUM, OUTPUT.
REQ-010 IDLE: on edge, SHALL register sample_in into fir_sample_o, clear done mask, clear accumulator, go START.
REQ-011 START: SHALL assert fir_valid_strobe_o for exactly this one cycle, then go WAIT.
REQ-012 SHALL OR fir_finished_i into the done mask every cycle in START and WAIT; pulses in START SHALL not be lost.
REQ-013 WAIT: when done mask (including this cycle's pulses) is all ones, SHALL go SUM next cycle and reset unit index to 0.
REQ-014 WAIT: SHALL count cycles; on reaching TIMEOUT with mask incomplete, SHALL set timeout_o and go SUM anyway.
REQ-015 SUM: SHALL add sign-extended fir_y_i unit[index] to accumulator, one unit per cycle, NUM_UNITS cycles, then go OUTPUT.
REQ-016 Accumulator SHALL be signed, width DATA_SIZE_FIR_OUT + $clog2(NUM_UNITS)+1; no overflow possible.
REQ-017 OUTPUT: SHALL register sample_out = saturate(acc >>> OUT_SHIFT) to signed DATA_SIZE range [-32768, 32767] for default; SHALL assert valid_strobe_out for this one cycle; go IDLE.
REQ-018 Latency: edge at cycle 0, fir_valid_strobe_o at cycle 1, if all done seen by cycle N then valid_strobe_out at cycle N+NUM_UNITS+2.
REQ-019 Edge while not IDLE SHALL drop the sample, leave fir_sample_o unchanged, set overrun_o.
REQ-020 Edge in the OUTPUT cycle SHALL count as overrun (not queued).
REQ-021 clear_i SHALL clear overrun_o and timeout_o next cycle; simultaneous set and clear SHALL leave the flag set.
REQ-022 sample_out SHALL hold its value until the next OUTPUT.
REQ-023 fir_finished_i pulses while IDLE/SUM/OUTPUT SHALL be ignored.

Reset
REQ-024 On rst_ni low, asynchronously: state IDLE; all outputs 0; done mask, counters, accumulator, edge register 0.
REQ-025 Reset mid-operation SHALL abandon the computation with no valid_strobe_out; first edge after release SHALL start normally.

Verification
REQ-026 NUM_UNITS=4, sample_in=0x1234, all units finish 5 cycles after strobe, y={0x8000,0x8000,0x8000,0x8000} -> fir_sample_o=0x1234, fir_valid_strobe_o 1 cycle, sample_out=0x0004 (0x20000>>>15), one valid_strobe_out at cycle 11.
REQ-027 y all 0x7FFFFFFF -> sample_out=0x7FFF; y all 0x80000000 -> sample_out=0x8000.
REQ-028 Units finish on different cycles (1,3,7,2) incl. pulse during START -> SUM entered after last pulse; unit pulse missed -> timeout_o=1 after 2048 WAIT cycles, result still output.
REQ-029 Second edge 3 cycles after first -> overrun_o=1, fir_sample_o unchanged, exactly one result; clear_i -> overrun_o=0.
REQ-030 valid_strobe_in held high 100 cycles -> exactly one computation.
REQ-031 rst_ni low during WAIT -> outputs 0, no valid_strobe_out; next edge gives correct result.
